// File: rtl/divmod_seq_if.sv
// Go/ready transaction bundle for divmod_seq: operands and mode in, flags and results out.
interface divmod_seq_if #(
    parameter int WIDTH_LOG = 4
);
    localparam int WIDTH = 1 << WIDTH_LOG;

    logic             go;
    logic             signed_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             error;
    logic             ovf;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    modport master (
        output go, signed_op, a, b,
        input  ready, error, ovf, quot, rem
    );

    modport slave (
        input  go, signed_op, a, b,
        output ready, error, ovf, quot, rem
    );
endinterface

// File: rtl/divmod_seq.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned per operation.
// Define DIVMOD_SEQ_EARLY_EXIT_EN to start from the leading-one distance instead of bit HI.
module divmod_seq #(
    parameter int WIDTH_LOG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    divmod_seq_if.slave  divBus
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int HI    = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_e;

    state_e               state_q,   state_d;
    logic [WIDTH-1:0]     magB_q,    magB_d;
    logic [WIDTH-1:0]     partRem_q, partRem_d;
    logic [WIDTH-1:0]     quotAcc_q, quotAcc_d;
    logic [WIDTH_LOG-1:0] shift_q,   shift_d;
    logic                 negQuot_q, negQuot_d;
    logic                 negRem_q,  negRem_d;
    logic                 error_q,   error_d;
    logic                 ovf_q,     ovf_d;
    logic [WIDTH-1:0]     quot_q,    quot_d;
    logic [WIDTH-1:0]     rem_q,     rem_d;

    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH_LOG-1:0] startShift;
    logic [2*WIDTH-1:0]   trial;
    logic                 trialFits;

    assign magA = (divBus.signed_op && divBus.a[HI]) ? -divBus.a : divBus.a;
    assign magB = (divBus.signed_op && divBus.b[HI]) ? -divBus.b : divBus.b;

`ifdef DIVMOD_SEQ_EARLY_EXIT_EN
    function automatic logic [WIDTH_LOG-1:0] msbIndex(input logic [WIDTH-1:0] v);
        logic [WIDTH_LOG-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = WIDTH_LOG'(i);
        end
        return idx;
    endfunction

    logic [WIDTH_LOG-1:0] msbA;
    logic [WIDTH_LOG-1:0] msbB;

    assign msbA       = msbIndex(magA);
    assign msbB       = msbIndex(magB);
    assign startShift = (msbA > msbB) ? (msbA - msbB) : '0;
`else
    assign startShift = WIDTH_LOG'(HI);
`endif

    // Double width keeps |b|<<shift exact even when a fixed start shift overshoots.
    assign trial     = {{WIDTH{1'b0}}, magB_q} << shift_q;
    assign trialFits = (trial <= {{WIDTH{1'b0}}, partRem_q});

    always_comb begin
        state_d   = state_q;
        magB_d    = magB_q;
        partRem_d = partRem_q;
        quotAcc_d = quotAcc_q;
        shift_d   = shift_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        error_d   = error_q;
        ovf_d     = ovf_q;
        quot_d    = quot_q;
        rem_d     = rem_q;

        case (state_q)
            IDLE: begin
                if (divBus.go) begin
                    if (divBus.b == '0) begin
                        error_d = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = divBus.a;
                    end else begin
                        magB_d    = magB;
                        partRem_d = magA;
                        quotAcc_d = '0;
                        shift_d   = startShift;
                        negQuot_d = divBus.signed_op & (divBus.a[HI] ^ divBus.b[HI]);
                        negRem_d  = divBus.signed_op & divBus.a[HI];
                        error_d   = 1'b0;
                        ovf_d     = divBus.signed_op
                                    && (divBus.a == {1'b1, {HI{1'b0}}})
                                    && (divBus.b == '1);
                        state_d   = DIV;
                    end
                end
            end
            DIV: begin
                if (trialFits) begin
                    partRem_d = partRem_q - trial[WIDTH-1:0];
                    quotAcc_d = quotAcc_q | (WIDTH'(1) << shift_q);
                end
                if (shift_q == '0) begin
                    state_d = FIX;
                end else begin
                    shift_d = shift_q - 1'b1;
                end
            end
            FIX: begin
                quot_d  = negQuot_q ? -quotAcc_q : quotAcc_q;
                rem_d   = negRem_q  ? -partRem_q : partRem_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            magB_q    <= '0;
            partRem_q <= '0;
            quotAcc_q <= '0;
            shift_q   <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            error_q   <= 1'b0;
            ovf_q     <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            magB_q    <= magB_d;
            partRem_q <= partRem_d;
            quotAcc_q <= quotAcc_d;
            shift_q   <= shift_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            error_q   <= error_d;
            ovf_q     <= ovf_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
        end
    end

    assign divBus.ready = (state_q == IDLE);
    assign divBus.error = error_q;
    assign divBus.ovf   = ovf_q;
    assign divBus.quot  = quot_q;
    assign divBus.rem   = rem_q;
endmodule

// File: tb/tb_divmod_seq.sv
// Scoreboard bench for divmod_seq: expected results and latency come from a behavioural model.
module tb_divmod_seq;
    localparam int WIDTH_LOG = 4;
    localparam int WIDTH     = 1 << WIDTH_LOG;

    typedef struct {
        logic [WIDTH-1:0] quot;
        logic [WIDTH-1:0] rem;
        logic             err;
        logic             ovf;
        int               lat;
    } expT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    divmod_seq_if #(.WIDTH_LOG(WIDTH_LOG)) divBus ();

    divmod_seq #(.WIDTH_LOG(WIDTH_LOG)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .divBus (divBus)
    );

    always #5 clk = ~clk;

    expT              scoreboard[$];
    int               testsRun    = 0;
    int               testsFailed = 0;
    logic [WIDTH-1:0] lastQuot    = '0;
    logic [WIDTH-1:0] lastRem     = '0;

    function automatic int msbIdx(input logic [WIDTH-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Reference results use the simulator's own signed/unsigned arithmetic.
    function automatic expT model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        expT              e;
        logic [WIDTH-1:0] ma;
        logic [WIDTH-1:0] mb;
        int               ms;
        e.err = 1'b0;
        e.ovf = 1'b0;
        if (b == '0) begin
            e.err  = 1'b1;
            e.quot = '1;
            e.rem  = a;
            e.lat  = 0;
            return e;
        end
        if (s) begin
            if (a == 16'h8000 && b == 16'hFFFF) begin
                e.quot = 16'h8000;
                e.rem  = '0;
                e.ovf  = 1'b1;
            end else begin
                e.quot = 16'($signed(a) / $signed(b));
                e.rem  = 16'($signed(a) % $signed(b));
            end
        end else begin
            e.quot = a / b;
            e.rem  = a % b;
        end
        ma = (s && a[WIDTH-1]) ? -a : a;
        mb = (s && b[WIDTH-1]) ? -b : b;
`ifdef DIVMOD_SEQ_EARLY_EXIT_EN
        ms    = (msbIdx(ma) > msbIdx(mb)) ? (msbIdx(ma) - msbIdx(mb)) : 0;
        e.lat = ms + 2;
`else
        ms    = msbIdx(ma) + msbIdx(mb);
        e.lat = WIDTH + 1 + (ms * 0);
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        divBus.go        = 1'b1;
        divBus.signed_op = s;
        divBus.a         = a;
        divBus.b         = b;
        scoreboard.push_back(model(s, a, b));
        @(posedge clk);
        @(negedge clk);
        divBus.go = 1'b0;
    endtask

    task automatic waitReady(input int start, output int edges);
        edges = start;
        while (divBus.ready !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        divBus.go        = 1'b1;
        divBus.signed_op = 1'b0;
        divBus.a         = 16'd5;
        divBus.b         = 16'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        divBus.go = 1'b0;
        testsRun++;
        if ({divBus.ready, divBus.error, divBus.ovf, divBus.quot, divBus.rem} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got ready=%b err=%b ovf=%b quot=%h rem=%h, want 1 0 0 0000 0000",
                     divBus.ready, divBus.error, divBus.ovf, divBus.quot, divBus.rem);
        end
        rst_n = 1'b1;
    endtask

    task automatic runTable(input string name, input logic s[], input logic [WIDTH-1:0] av[], input logic [WIDTH-1:0] bv[]);
        expT e;
        int  lat;
        for (int i = 0; i < av.size(); i++) begin
            applyStimulus(s[i], av[i], bv[i]);
            waitReady(0, lat);
            e = scoreboard.pop_front();
            testsRun++;
            if ({divBus.error, divBus.ovf, divBus.quot, divBus.rem} !== {e.err, e.ovf, e.quot, e.rem}) begin
                testsFailed++;
                $display("[TB] FAIL %s_result[%0d] a=%h b=%h s=%b: got err=%b ovf=%b quot=%h rem=%h, want err=%b ovf=%b quot=%h rem=%h",
                         name, i, av[i], bv[i], s[i], divBus.error, divBus.ovf, divBus.quot, divBus.rem,
                         e.err, e.ovf, e.quot, e.rem);
            end
            testsRun++;
            if (lat !== e.lat) begin
                testsFailed++;
                $display("[TB] FAIL %s_latency[%0d]: got %0d edges, want %0d", name, i, lat, e.lat);
            end
            lastQuot = e.quot;
            lastRem  = e.rem;
        end
    endtask

    task automatic test_unsigned();
        runTable("unsigned", '{1'b0, 1'b0, 1'b0}, '{16'd100, 16'hFFFF, 16'd5000}, '{16'd7, 16'd1, 16'd5000});
    endtask

    task automatic test_signed();
        runTable("signed", '{1'b1, 1'b1, 1'b1}, '{16'hFFF9, 16'd7, 16'hFFF9}, '{16'd2, 16'hFFFE, 16'hFFFE});
    endtask

    task automatic test_div_zero();
        runTable("div_zero", '{1'b0, 1'b0, 1'b1}, '{16'h1234, 16'd9, 16'h8001}, '{16'h0000, 16'd3, 16'h0000});
    endtask

    task automatic test_overflow();
        expT e;
        int  lat;
        applyStimulus(1'b1, 16'h8000, 16'hFFFF);
        testsRun++;
        if ({divBus.ready, divBus.ovf, divBus.error, divBus.quot, divBus.rem} !== {1'b0, 1'b1, 1'b0, lastQuot, lastRem}) begin
            testsFailed++;
            $display("[TB] FAIL ovf_at_accept: got ready=%b ovf=%b err=%b quot=%h rem=%h, want 0 1 0 %h %h",
                     divBus.ready, divBus.ovf, divBus.error, divBus.quot, divBus.rem, lastQuot, lastRem);
        end
        waitReady(0, lat);
        e = scoreboard.pop_front();
        testsRun++;
        if ({divBus.error, divBus.ovf, divBus.quot, divBus.rem, lat} !== {e.err, e.ovf, e.quot, e.rem, e.lat}) begin
            testsFailed++;
            $display("[TB] FAIL ovf_result: got ovf=%b quot=%h rem=%h lat=%0d, want ovf=%b quot=%h rem=%h lat=%0d",
                     divBus.ovf, divBus.quot, divBus.rem, lat, e.ovf, e.quot, e.rem, e.lat);
        end
        lastQuot = e.quot;
        lastRem  = e.rem;
        runTable("min_unsigned", '{1'b0}, '{16'h8000}, '{16'hFFFF});
    endtask

    task automatic test_ignored_go();
        expT e;
        int  lat;
        applyStimulus(1'b0, 16'd3, 16'd5);
        divBus.go = 1'b1;
        divBus.a  = 16'd99;
        divBus.b  = 16'd1;
        @(negedge clk);
        divBus.go = 1'b0;
        waitReady(1, lat);
        e = scoreboard.pop_front();
        testsRun++;
        if ({divBus.error, divBus.ovf, divBus.quot, divBus.rem, lat} !== {e.err, e.ovf, e.quot, e.rem, e.lat}) begin
            testsFailed++;
            $display("[TB] FAIL ignored_go: got quot=%h rem=%h lat=%0d, want quot=%h rem=%h lat=%0d",
                     divBus.quot, divBus.rem, lat, e.quot, e.rem, e.lat);
        end
        repeat (3) @(negedge clk);
        testsRun++;
        if ({divBus.ready, divBus.quot, divBus.rem} !== {1'b1, e.quot, e.rem}) begin
            testsFailed++;
            $display("[TB] FAIL ignored_go_hold: got ready=%b quot=%h rem=%h, want 1 %h %h",
                     divBus.ready, divBus.quot, divBus.rem, e.quot, e.rem);
        end
        lastQuot = e.quot;
        lastRem  = e.rem;
    endtask

    task automatic test_reset_mid_op();
        expT e;
        applyStimulus(1'b0, 16'hFFFF, 16'd1);
        e = scoreboard.pop_back();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        testsRun++;
        if ({divBus.ready, divBus.error, divBus.ovf, divBus.quot, divBus.rem} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_op: got ready=%b err=%b ovf=%b quot=%h rem=%h (dropped quot=%h), want 1 0 0 0000 0000",
                     divBus.ready, divBus.error, divBus.ovf, divBus.quot, divBus.rem, e.quot);
        end
        rst_n    = 1'b1;
        lastQuot = '0;
        lastRem  = '0;
        runTable("after_reset", '{1'b0, 1'b1}, '{16'd1000, 16'hFC18}, '{16'd10, 16'd33});
    endtask

    task automatic test_back_to_back();
        logic             s[];
        logic [WIDTH-1:0] av[];
        logic [WIDTH-1:0] bv[];
        s  = new[10];
        av = new[10];
        bv = new[10];
        for (int i = 0; i < 10; i++) begin
            s[i]  = 1'($urandom_range(0, 1));
            av[i] = 16'($urandom);
            bv[i] = (i == 4) ? 16'h0 : ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom_range(1, 65535));
        end
        runTable("back_to_back", s, av, bv);
    endtask

    initial begin
        divBus.go        = 1'b0;
        divBus.signed_op = 1'b0;
        divBus.a         = '0;
        divBus.b         = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignored_go();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
